// File: rtl/inst_cfg_sequencer.sv
// Shares one parameter-configuration write port among NUM_INST instance slots.
// Round-robin picks a slot, then two handshaked writes (A, then B) and a done pulse.
module inst_cfg_sequencer #(
  parameter int NUM_INST = 4,
  parameter int DATA_W   = 16,
  parameter int IDX_W    = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_INST-1:0]        req,
  input  logic [NUM_INST*DATA_W-1:0] req_a,
  input  logic [NUM_INST*DATA_W-1:0] req_b,
  output logic [NUM_INST-1:0]        done,
  output logic                       busy,
  output logic                       cfg_valid,
  input  logic                       cfg_ready,
  output logic [IDX_W-1:0]           cfg_inst,
  output logic                       cfg_sel,
  output logic [DATA_W-1:0]          cfg_data,
  output logic                       cfg_last
);

  typedef enum logic [1:0] {IDLE, SEND_A, SEND_B, ST_DONE} state_t;

  state_t                state_q, state_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [IDX_W-1:0]      last_grant_q, last_grant_d;
  logic [DATA_W-1:0]     a_q, a_d, b_q, b_d;
  logic [NUM_INST-1:0]   done_q, done_d;
  logic                  busy_q, busy_d;
  logic                  cfg_valid_q, cfg_valid_d;
  logic [IDX_W-1:0]      cfg_inst_q, cfg_inst_d;
  logic                  cfg_sel_q, cfg_sel_d;
  logic [DATA_W-1:0]     cfg_data_q, cfg_data_d;
  logic                  cfg_last_q, cfg_last_d;

  logic                  grant_vld;
  logic [IDX_W-1:0]      grant_idx;
  logic [IDX_W-1:0]      cand;
  logic                  hs;

  // First set request strictly after last_grant, wrapping around.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    cand      = '0;
    for (int k = 1; k <= NUM_INST; k++) begin
      cand = IDX_W'((int'(last_grant_q) + k) % NUM_INST);
      if (!grant_vld && req[cand]) begin
        grant_vld = 1'b1;
        grant_idx = cand;
      end
    end
  end

  assign hs = cfg_valid_q && cfg_ready;

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    a_d          = a_q;
    b_d          = b_q;
    last_grant_d = last_grant_q;
    case (state_q)
      IDLE: begin
        if (grant_vld) begin
          state_d = SEND_A;
          idx_d   = grant_idx;
          a_d     = req_a[int'(grant_idx)*DATA_W +: DATA_W];
          b_d     = req_b[int'(grant_idx)*DATA_W +: DATA_W];
        end
      end
      SEND_A:  if (hs) state_d = SEND_B;
      SEND_B:  if (hs) state_d = ST_DONE;
      ST_DONE: begin
        state_d      = IDLE;
        last_grant_d = idx_q;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so every port comes straight off a flop.
  always_comb begin
    busy_d      = (state_d != IDLE);
    cfg_valid_d = (state_d == SEND_A) || (state_d == SEND_B);
    cfg_sel_d   = (state_d == SEND_B);
    cfg_last_d  = (state_d == SEND_B);
    cfg_inst_d  = (state_d == IDLE) ? '0 : idx_d;
    cfg_data_d  = '0;
    if (state_d == SEND_A) cfg_data_d = a_d;
    if (state_d == SEND_B) cfg_data_d = b_d;
    done_d = '0;
    if (state_d == ST_DONE) done_d[idx_d] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      last_grant_q <= IDX_W'(NUM_INST - 1);
      a_q          <= '0;
      b_q          <= '0;
      done_q       <= '0;
      busy_q       <= 1'b0;
      cfg_valid_q  <= 1'b0;
      cfg_inst_q   <= '0;
      cfg_sel_q    <= 1'b0;
      cfg_data_q   <= '0;
      cfg_last_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      last_grant_q <= last_grant_d;
      a_q          <= a_d;
      b_q          <= b_d;
      done_q       <= done_d;
      busy_q       <= busy_d;
      cfg_valid_q  <= cfg_valid_d;
      cfg_inst_q   <= cfg_inst_d;
      cfg_sel_q    <= cfg_sel_d;
      cfg_data_q   <= cfg_data_d;
      cfg_last_q   <= cfg_last_d;
    end
  end

  assign done      = done_q;
  assign busy      = busy_q;
  assign cfg_valid = cfg_valid_q;
  assign cfg_inst  = cfg_inst_q;
  assign cfg_sel   = cfg_sel_q;
  assign cfg_data  = cfg_data_q;
  assign cfg_last  = cfg_last_q;

endmodule

// File: doc/inst_cfg_sequencer.md
Name: inst_cfg_sequencer

Overview:
- Shares one parameter-configuration bus among NUM_INST module instances.
- Each instance slot requests a load of its two parameter values (A then B, matching the `.a()`/`.b()` override pair on parameterised instances).
- Round-robin arbitration picks one slot; an FSM issues two bus writes with valid/ready handshake, then pulses a per-slot done.
- Sits between instance-level config requesters and the single shared config write port.

Parameters:
- NUM_INST, 4, number of requesting instance slots (2..16).
- DATA_W, 16, width of each parameter value.
- IDX_W, 2, width of the instance index; must equal clog2(NUM_INST).

Ports:
- clk  input  1  clock; all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- req  input  NUM_INST  per-slot load request; held high until that slot's done.
- req_a  input  NUM_INST*DATA_W  per-slot A value; slot i at bits [i*DATA_W +: DATA_W].
- req_b  input  NUM_INST*DATA_W  per-slot B value; same packing as req_a.
- done  output  NUM_INST  one-cycle completion pulse for the served slot.
- busy  output  1  high whenever state is not IDLE.
- cfg_valid  output  1  config write valid.
- cfg_ready  input  1  config write accepted when valid and ready are both high.
- cfg_inst  output  IDX_W  target instance index.
- cfg_sel  output  1  0 = parameter A, 1 = parameter B.
- cfg_data  output  DATA_W  parameter value.
- cfg_last  output  1  high on the final (B) write of a transaction.

Behaviour:
- Reset:
  - State goes to IDLE.
  - done, busy, cfg_valid, cfg_inst, cfg_sel, cfg_data and cfg_last all go to 0.
  - Round-robin pointer last_grant resets to NUM_INST-1, so slot 0 has first priority.
- States: IDLE, SEND_A, SEND_B, DONE.
- IDLE:
  - If any req bit is set, grant the first set bit searching from last_grant+1 upward, wrapping modulo NUM_INST.
  - In the same cycle, latch the granted index and that slot's A and B values into internal registers.
  - Next state is SEND_A. If no req bit is set, stay in IDLE.
- SEND_A:
  - Drive cfg_valid=1, cfg_sel=0, cfg_last=0, cfg_inst=idx, cfg_data=A.
  - On cfg_valid&&cfg_ready, go to SEND_B; otherwise hold.
- SEND_B:
  - Drive cfg_valid=1, cfg_sel=1, cfg_last=1, cfg_inst=idx, cfg_data=B.
  - On the handshake, go to DONE.
- DONE:
  - Drive cfg_valid=0 and done[idx]=1 for exactly one cycle.
  - Set last_grant=idx, then return to IDLE.
- Output timing:
  - All outputs are registered.
  - First cfg_valid appears 1 cycle after the IDLE cycle in which the grant is made.
  - Minimum transaction length is 4 cycles (IDLE, A, B, DONE) with cfg_ready held high.
- Valid stability: while cfg_valid=1 and cfg_ready=0, cfg_inst, cfg_sel, cfg_data and cfg_last hold constant. cfg_valid never drops without a handshake.
- Data capture:
  - Latched values are used for the whole transaction.
  - Changes to req_a/req_b after the grant are ignored.
- Requests are sampled only in IDLE:
  - Requests arriving during a transaction wait.
  - A requester drops req on the edge after its done, so it is low in the following IDLE.
  - A requester that keeps req high re-enters arbitration behind the other pending slots.
- Dropped request: if req[idx] falls mid-transaction, the transaction still completes and done still pulses.
- Fairness: with all slots requesting continuously, grants rotate 0,1,…,NUM_INST-1,0.
- Reset mid-operation: the partial transaction is abandoned with no done pulse, cfg_valid drops on the cycle after rst, and the pointer restarts at slot 0.
- cfg_ready while cfg_valid=0 is ignored.

Test Plan:
- Single request, cfg_ready=1:
  - Stimulus: req=4'b0100, A=16'h000C, B=16'h0022.
  - Required: cfg writes (inst=2, sel=0, data=000C), then (inst=2, sel=1, data=0022, last=1).
  - Required: done=4'b0100 for one cycle; busy high for 3 cycles.
- Backpressure:
  - Stimulus: same request, cfg_ready low for 5 cycles in SEND_A, then toggled 0/1 in SEND_B.
  - Required: cfg outputs stable while stalled; exactly 2 handshakes; done after the second.
- Simultaneous requests:
  - Stimulus: req=4'b1111 held, each requester dropping its req after its done.
  - Required: grant order 0,1,2,3; done pulses 4 transactions apart (16 cycles total with ready=1).
- Fairness and wrap:
  - Stimulus: slots 1 and 3 request continuously.
  - Required: order 1,3,1,3; pointer wraps from 3 to slot 1.
- Reset mid-transaction:
  - Stimulus: assert rst for 1 cycle while in SEND_B with cfg_ready=0.
  - Required: cfg_valid=0 and busy=0 next cycle; no done; the next req=4'b1000 is served starting at slot 3 with the pointer at its reset value.
- Request drop and data change:
  - Stimulus: req[1] falls and req_a[1] changes during SEND_A.
  - Required: original latched A and B are written and done[1] still pulses.
